// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, data width and baud divisor helper.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; resets to 1 (idle line).
`timescale 1ns/1ps
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling with a bit-period counter, one-cycle
// rx_done strobe when a byte with a valid stop bit lands in rx_data.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int BW           = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state_q;
  logic [CW-1:0]        clk_cnt_q;
  logic [BW-1:0]        bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_done_q;

  sync_2ff u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rx_serial),
    .q_o  (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      rx_done_q <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          clk_cnt_q <= '0;
          if (!rx_s) state_q <= START;
        end
        START: begin
          // Re-check the line at mid start bit so short glitches are dropped.
          if (clk_cnt_q == HALF_LAST) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q          <= '0;
            shift_q[bit_idx_q] <= rx_s;
            if (bit_idx_q == IDX_LAST) state_q <= STOP;
            else                       bit_idx_q <= bit_idx_q + BW'(1);
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        STOP: begin
          // Leave at mid-stop so a following start edge is caught early.
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            state_q   <= IDLE;
            if (rx_s) begin
              rx_data_q <= shift_q;
              rx_done_q <= 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data = rx_data_q;
  assign rx_done = rx_done_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are queued into a byte-level model and
// every done strobe / every idle cycle of rx_data is checked against it.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 500_000;
  localparam int NOM      = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_serial(rx_serial),
    .rx_data  (rx_data),
    .rx_done  (rx_done)
  );

  always #10 clk = ~clk;

  int         n_chk = 0, n_fail = 0;
  int         n_done = 0, n_exp = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_data = 8'h00;
  logic       prev_done = 1'b0;
  logic       mon_en = 1'b0;
  time        t_done = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Frame = start(0), 8 data bits LSB first, stop; only good frames are expected.
  task automatic send(input logic [7:0] b, input logic stop, input int per, input int gap);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (stop) begin
      exp_q.push_back(b);
      n_exp++;
    end
    for (int i = 0; i < 10; i++) begin
      rx_serial = f[i];
      wclk(per);
    end
    rx_serial = 1'b1;
    wclk(gap);
  endtask

  task automatic do_reset();
    n_exp      = n_exp - exp_q.size();
    exp_q.delete();
    model_data = 8'h00;
    rst_n      = 1'b0;
    rx_serial  = 1'b1;
    wclk(5);
    rst_n = 1'b1;
    wclk(5);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rx_done) begin
        n_done++;
        t_done = $time;
        chk("done_single", {31'd0, prev_done}, 0);
        chk("done_expected", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          model_data = exp_q.pop_front();
          chk("rx_data", {24'd0, rx_data}, {24'd0, model_data});
        end
      end else begin
        chk("rx_data_hold", {24'd0, rx_data}, {24'd0, model_data});
      end
      prev_done = rx_done;
    end
  end

  initial begin
    time        t0;
    logic [7:0] b;
    int         per, gap;
    logic [9:0] f;

    // 1: reset
    rx_serial = 1'b1;
    wclk(5);
    rst_n = 1'b1;
    wclk(5);
    mon_en = 1'b1;
    chk("reset_data", {24'd0, rx_data}, 0);
    chk("reset_done", {31'd0, rx_done}, 0);

    // 2: single byte with latency window around 9.5 bit times
    t0 = $time;
    send(8'hA5, 1'b1, NOM, 2 * NOM);
    chk("a5_count", n_done, n_exp);
    chk("a5_latency", {31'd0, ((t_done - t0) / 20 >= 945) && ((t_done - t0) / 20 <= 965)}, 1);
    chk("a5_data", {24'd0, rx_data}, 32'hA5);

    // 3: glitch rejection then a clean frame
    rx_serial = 1'b0;
    wclk(20);
    rx_serial = 1'b1;
    wclk(2 * NOM);
    chk("glitch_count", n_done, n_exp);
    send(8'h3C, 1'b1, NOM, NOM);
    chk("3c_data", {24'd0, rx_data}, 32'h3C);

    // 4: framing error keeps previous byte
    send(8'hA5, 1'b1, NOM, NOM);
    send(8'h5A, 1'b0, NOM, 2 * NOM);
    chk("frame_err_count", n_done, n_exp);
    chk("frame_err_data", {24'd0, rx_data}, 32'hA5);

    // 5: back-to-back
    send(8'h00, 1'b1, NOM, 0);
    send(8'hFF, 1'b1, NOM, 0);
    send(8'h81, 1'b1, NOM, NOM);
    chk("b2b_count", n_done, n_exp);
    chk("b2b_last", {24'd0, rx_data}, 32'h81);

    // 6: reset during data bit 4 of 0x55
    f = {1'b1, 8'h55, 1'b0};
    exp_q.push_back(8'h55);
    n_exp++;
    for (int i = 0; i < 5; i++) begin
      rx_serial = f[i];
      wclk(NOM);
    end
    rx_serial = f[5];
    wclk(NOM / 2);
    do_reset();
    chk("midrst_data", {24'd0, rx_data}, 0);
    chk("midrst_count", n_done, n_exp);
    send(8'hC3, 1'b1, NOM, NOM);
    chk("c3_data", {24'd0, rx_data}, 32'hC3);

    // Random frames with +/-3% transmitter period and occasional framing errors
    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        send(b, 1'b0, NOM, 2 * NOM);
      end else begin
        per = $urandom_range(NOM - 3, NOM + 3);
        gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 2 * NOM);
        send(b, 1'b1, per, gap);
      end
    end
    wclk(2 * NOM);
    chk("rand_count", n_done, n_exp);
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, 8N1 framing: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Samples an asynchronous serial line in the system clock domain using a bit-period counter and mid-bit sampling.
- Delivers each good byte on a parallel output with a one-cycle done strobe.
- Sits between the board RX pin and the byte consumer (FIFO or command parser).

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (5208 at defaults), clocks per bit; derived localparam, not overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_serial  input  1  serial line; idles high; asynchronous to clk.
- rx_data  output  8  last correctly received byte.
- rx_done  output  1  one-cycle pulse when rx_data is updated.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - rx_data = 0x00, rx_done = 0, state = IDLE, counters = 0.
  - Synchronizer flops reset to 1 (line idle).
- Input sync: rx_serial passes through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
- States: IDLE, START, DATA, STOP.
- IDLE: on rx_s == 0, go to START and clear the clock counter.
- START:
  - Count to CLKS_PER_BIT/2 - 1 (mid start bit), then sample.
  - rx_s == 0: go to DATA; clear the clock counter and bit index.
  - rx_s == 1: glitch; return to IDLE with no output change.
- DATA:
  - Each bit is sampled after a further CLKS_PER_BIT clocks (mid-bit).
  - Sample goes into shift-register position bit_idx (0..7, LSB first).
  - After bit 7 is sampled, go to STOP.
- STOP:
  - Sample after CLKS_PER_BIT clocks.
  - rx_s == 1: load rx_data with the shift register and assert rx_done for exactly one cycle.
  - rx_s == 0 (framing error): discard the byte; rx_data holds; no rx_done.
  - In both cases go to IDLE on the next cycle, so a following start bit is detected from mid-stop onward.
- rx_done:
  - Registered; high only in the cycle after the stop sample.
  - Never high for two consecutive cycles.
- rx_data: changes only together with rx_done; stable otherwise.
- Tolerance: mid-bit sampling must accept a transmitter bit period within ±3% of nominal (e.g. 5200 clk bits against 5208).
- Reset mid-frame: state returns to IDLE immediately; the partial byte is lost; no rx_done.
- A low line held continuously after a framing error: IDLE re-enters START on the next cycle (treated as a new start).

Decomposition:
- Shared package uart_pkg:
  - State enum (IDLE, START, DATA, STOP).
  - Data width constant DATA_BITS = 8.
  - Function computing CLKS_PER_BIT from CLK_FREQ and BAUD (shared with uart_tx).
- Optional sub-module sync_2ff (1-bit, reset to 1) for the input synchronizer; the rest is a single FSM with a clock counter and a bit counter.

Test Plan:
1. Reset:
   - Stimulus: rx_serial = 1, rst_n low 100 ns, then release, idle 100 ns.
   - Required: rx_data = 0x00, rx_done = 0 throughout.
2. Single byte:
   - Stimulus: send 0xA5 (bits 1,0,1,0,0,1,0,1) with a 104 µs bit time at a 50 MHz clock.
   - Required: exactly one rx_done pulse about 9.5 bit times (~990 µs) after the start edge; rx_data = 0xA5; no further pulses during 200 µs idle.
3. Glitch rejection:
   - Stimulus: rx_serial low for 1 µs (50 clocks), then high.
   - Required: no rx_done; FSM back in IDLE; a subsequent 0x3C frame is received correctly.
4. Framing error:
   - Stimulus: send 0x5A with stop bit = 0.
   - Required: no rx_done; rx_data keeps its previous value (0xA5).
5. Back-to-back frames:
   - Stimulus: 0x00 immediately followed by 0xFF, then 0x81, with no idle gap.
   - Required: three rx_done pulses with rx_data = 0x00, 0xFF, 0x81 in order.
6. Reset mid-frame:
   - Stimulus: assert rst_n during data bit 4 of 0x55, release, then send 0xC3.
   - Required: no rx_done for 0x55; rx_data = 0x00 after reset; 0xC3 received with one pulse.
